// File: rtl/rw_arb_pkg.sv
// Shared definitions for the read/write port arbiter: FSM state encoding,
// transfer size codes and the width of the granted-master id.
package rw_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam logic [1:0] SIZE_BYTE  = 2'b00;
  localparam logic [1:0] SIZE_HALF  = 2'b01;
  localparam logic [1:0] SIZE_WORD  = 2'b10;
  localparam logic [1:0] SIZE_DWORD = 2'b11;

  localparam int RW_ID_W = 4;

endpackage

// File: rtl/rr_picker.sv
// Combinational winner search: first set bit of validI starting at startI,
// wrapping modulo N. A start of zero gives plain lowest-index priority.
module rr_picker #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     validI,
  input  logic [IDX_W-1:0] startI,
  output logic [IDX_W-1:0] winnerO,
  output logic             foundO
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest candidate back to the start so the closest valid one wins.
  always_comb begin
    winnerO = '0;
    foundO  = 1'b0;
    cand    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = IDX_W'((32'(startI) + 32'(k)) % 32'(N));
      if (validI[cand]) begin
        winnerO = cand;
        foundO  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rw_port_arbiter.sv
// N-master arbiter onto the single axi_rw port: registered grant held for a
// whole transaction, fixed-priority or round-robin selection.
module rw_port_arbiter
  import rw_arb_pkg::*;
#(
  parameter int N_MASTERS     = 2,
  parameter int RW_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH    = 64,
  parameter int RR_MODE       = 0
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [N_MASTERS-1:0]              m_valid,
  output logic [N_MASTERS-1:0]              m_ready,
  input  logic [N_MASTERS-1:0]              m_req,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0]   m_addr,
  input  logic [2*N_MASTERS-1:0]            m_size,
  input  logic [N_MASTERS*RW_DATA_WIDTH-1:0] m_data_write,
  output logic [RW_DATA_WIDTH-1:0]          m_data_read,
  output logic [1:0]                        m_resp,
  output logic                              rw_valid,
  input  logic                              rw_ready,
  output logic                              rw_req,
  output logic [ADDR_WIDTH-1:0]             rw_addr,
  output logic [1:0]                        rw_size,
  output logic [RW_DATA_WIDTH-1:0]          data_write,
  input  logic [RW_DATA_WIDTH-1:0]          data_read,
  input  logic [1:0]                        rw_resp,
  output logic [RW_ID_W-1:0]                rw_id
);

  localparam int IDX_W = $clog2(N_MASTERS);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rrPtr_q, rrPtr_d;
  logic [IDX_W-1:0] pickStart;
  logic [IDX_W-1:0] pickWinner;
  logic             pickFound;

  assign pickStart = (RR_MODE != 0) ? rrPtr_q : '0;

  rr_picker #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) uPicker (
    .validI  (m_valid),
    .startI  (pickStart),
    .winnerO (pickWinner),
    .foundO  (pickFound)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      rrPtr_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rrPtr_q <= rrPtr_d;
    end
  end

  // A granted master dropping its valid aborts the transaction without a
  // completion and without advancing the round-robin pointer.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rrPtr_d  = rrPtr_q;
    rw_valid = 1'b0;
    m_ready  = '0;
    case (state_q)
      IDLE: begin
        if (pickFound) begin
          grant_d = pickWinner;
          state_d = BUSY;
        end
      end
      BUSY: begin
        rw_valid = m_valid[grant_q];
        if (!m_valid[grant_q]) begin
          state_d = IDLE;
        end else if (rw_ready) begin
          m_ready[grant_q] = 1'b1;
          state_d          = IDLE;
          if (RR_MODE != 0) begin
            rrPtr_d = IDX_W'((32'(grant_q) + 32'd1) % 32'(N_MASTERS));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rw_req      = m_req[grant_q];
  assign rw_addr     = m_addr[grant_q*ADDR_WIDTH +: ADDR_WIDTH];
  assign rw_size     = m_size[grant_q*2 +: 2];
  assign data_write  = m_data_write[grant_q*RW_DATA_WIDTH +: RW_DATA_WIDTH];
  assign rw_id       = RW_ID_W'(grant_q);
  assign m_data_read = data_read;
  assign m_resp      = rw_resp;

endmodule

// File: tb/tb_rw_port_arbiter.sv
// Directed bench: a 2-master fixed-priority arbiter and a 4-master round-robin
// arbiter share clock and reset; expected values are hand-computed.
module tb_rw_port_arbiter;

  logic clock;
  logic reset;

  logic [1:0]   aValid, aReady, aReq;
  logic [127:0] aAddr;
  logic [3:0]   aSize;
  logic [127:0] aWdata;
  logic [63:0]  aMdataRead;
  logic [1:0]   aMresp;
  logic         aRwValid, aRwReady, aRwReq;
  logic [63:0]  aRwAddr, aDataWrite, aDataRead;
  logic [1:0]   aRwSize, aRwResp;
  logic [3:0]   aRwId;

  logic [3:0]   bValid, bReady, bReq;
  logic [255:0] bAddr;
  logic [7:0]   bSize;
  logic [255:0] bWdata;
  logic [63:0]  bMdataRead;
  logic [1:0]   bMresp;
  logic         bRwValid, bRwReady, bRwReq;
  logic [63:0]  bRwAddr, bDataWrite, bDataRead;
  logic [1:0]   bRwSize, bRwResp;
  logic [3:0]   bRwId;

  int total = 0;
  int bad   = 0;

  rw_port_arbiter #(
    .N_MASTERS(2), .RW_DATA_WIDTH(64), .ADDR_WIDTH(64), .RR_MODE(0)
  ) dutA (
    .clock(clock), .reset(reset),
    .m_valid(aValid), .m_ready(aReady), .m_req(aReq), .m_addr(aAddr),
    .m_size(aSize), .m_data_write(aWdata), .m_data_read(aMdataRead),
    .m_resp(aMresp), .rw_valid(aRwValid), .rw_ready(aRwReady),
    .rw_req(aRwReq), .rw_addr(aRwAddr), .rw_size(aRwSize),
    .data_write(aDataWrite), .data_read(aDataRead), .rw_resp(aRwResp),
    .rw_id(aRwId)
  );

  rw_port_arbiter #(
    .N_MASTERS(4), .RW_DATA_WIDTH(64), .ADDR_WIDTH(64), .RR_MODE(1)
  ) dutB (
    .clock(clock), .reset(reset),
    .m_valid(bValid), .m_ready(bReady), .m_req(bReq), .m_addr(bAddr),
    .m_size(bSize), .m_data_write(bWdata), .m_data_read(bMdataRead),
    .m_resp(bMresp), .rw_valid(bRwValid), .rw_ready(bRwReady),
    .rw_req(bRwReq), .rw_addr(bRwAddr), .rw_size(bRwSize),
    .data_write(bDataWrite), .data_read(bDataRead), .rw_resp(bRwResp),
    .rw_id(bRwId)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    aValid = '0; aReq = '0; aAddr = '0; aSize = '0; aWdata = '0;
    aRwReady = 1'b0; aDataRead = '0; aRwResp = '0;
    bValid = '0; bReq = '0; bAddr = '0; bSize = '0; bWdata = '0;
    bRwReady = 1'b0; bDataRead = '0; bRwResp = '0;
    aAddr[63:0]    = 64'h0000_0000_0000_1000;
    aAddr[127:64]  = 64'h0000_0000_8000_0000;
    for (int i = 0; i < 4; i++) bAddr[i*64 +: 64] = 64'h100 * (i + 1);

    tick(); tick();
    reset = 1'b0;
    #1;
    checkOutput("rstValidA", 64'(aRwValid), 64'd0);
    checkOutput("rstReadyA", 64'(aReady), 64'd0);
    checkOutput("rstIdA", 64'(aRwId), 64'd0);
    checkOutput("rstAddrA", aRwAddr, 64'h1000);
    checkOutput("rstValidB", 64'(bRwValid), 64'd0);

    // Round-robin on B with all four masters requesting.
    bValid = 4'b1111;
    #1;
    checkOutput("rrIdleValid", 64'(bRwValid), 64'd0);
    for (int n = 0; n < 5; n++) begin
      tick();
      checkOutput("rrValid", 64'(bRwValid), 64'd1);
      checkOutput("rrId", 64'(bRwId), 64'(n % 4));
      checkOutput("rrAddr", bRwAddr, 64'h100 * ((n % 4) + 1));
      bRwReady = 1'b1;
      #1;
      checkOutput("rrReady", 64'(bReady), 64'(4'b0001 << (n % 4)));
      tick();
      bRwReady = 1'b0;
      #1;
      checkOutput("rrBubble", 64'(bRwValid), 64'd0);
      checkOutput("rrBubbleRdy", 64'(bReady), 64'd0);
    end
    bValid = 4'b0000;

    // Abort on B: pointer is at 1, so masters {2,3} grant master 2.
    tick();
    bValid = 4'b1100;
    tick();
    checkOutput("abortGrantId", 64'(bRwId), 64'd2);
    bValid = 4'b1000;
    bRwReady = 1'b1;
    #1;
    checkOutput("abortNoReady", 64'(bReady), 64'd0);
    checkOutput("abortNoValid", 64'(bRwValid), 64'd0);
    tick();
    bRwReady = 1'b0;
    bValid = 4'b1100;
    #1;
    checkOutput("abortIdleRdy", 64'(bReady), 64'd0);
    checkOutput("abortIdleValid", 64'(bRwValid), 64'd0);
    tick();
    checkOutput("abortRegrantId", 64'(bRwId), 64'd2);
    checkOutput("abortRegrantValid", 64'(bRwValid), 64'd1);
    bRwReady = 1'b1;
    #1;
    checkOutput("abortRegrantRdy", 64'(bReady), 64'b0100);
    tick();
    bRwReady = 1'b0;
    bValid = '0;

    // Single request on A from master 1.
    aValid = 2'b10;
    #1;
    checkOutput("singleIdle", 64'(aRwValid), 64'd0);
    tick();
    checkOutput("singleValid", 64'(aRwValid), 64'd1);
    checkOutput("singleId", 64'(aRwId), 64'd1);
    checkOutput("singleAddr", aRwAddr, 64'h8000_0000);
    checkOutput("singleEarlyRdy", 64'(aReady), 64'd0);
    aRwReady = 1'b1;
    #1;
    checkOutput("singleReady", 64'(aReady), 64'b10);
    tick();
    aRwReady = 1'b0;
    aValid = 2'b00;
    #1;
    checkOutput("singleAfterRdy", 64'(aReady), 64'd0);
    checkOutput("singleAfterValid", 64'(aRwValid), 64'd0);

    // Fixed priority: master 1 starves while master 0 stays valid.
    aValid = 2'b11;
    for (int n = 0; n < 3; n++) begin
      tick();
      checkOutput("fixId", 64'(aRwId), 64'd0);
      checkOutput("fixValid", 64'(aRwValid), 64'd1);
      aRwReady = 1'b1;
      #1;
      checkOutput("fixReady", 64'(aReady), 64'b01);
      tick();
      aRwReady = 1'b0;
      #1;
      checkOutput("fixBubble", 64'(aRwValid), 64'd0);
    end
    aValid = 2'b00;

    // Write path on A from master 0.
    aReq = 2'b01;
    aWdata[63:0] = 64'hDEAD_BEEF_0000_0001;
    aSize[1:0] = 2'b11;
    aValid = 2'b01;
    tick();
    checkOutput("wrReq", 64'(aRwReq), 64'd1);
    checkOutput("wrData", aDataWrite, 64'hDEAD_BEEF_0000_0001);
    checkOutput("wrSize", 64'(aRwSize), 64'd3);
    aRwResp = 2'b10;
    aDataRead = 64'h1234_5678;
    #1;
    checkOutput("wrRespPass", 64'(aMresp), 64'd2);
    checkOutput("wrReadPass", aMdataRead, 64'h1234_5678);
    aRwResp = 2'b00;
    aRwReady = 1'b1;
    #1;
    checkOutput("wrResp", 64'(aMresp), 64'd0);
    checkOutput("wrReady", 64'(aReady), 64'b01);
    tick();
    aRwReady = 1'b0;
    aValid = 2'b00;
    aReq = 2'b00;

    // Mid-transaction reset on A, then the pending request is re-granted.
    aValid = 2'b10;
    tick();
    checkOutput("mrBusyId", 64'(aRwId), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checkOutput("mrValid", 64'(aRwValid), 64'd0);
    checkOutput("mrReady", 64'(aReady), 64'd0);
    checkOutput("mrId", 64'(aRwId), 64'd0);
    tick();
    checkOutput("mrRegrantValid", 64'(aRwValid), 64'd1);
    checkOutput("mrRegrantId", 64'(aRwId), 64'd1);
    aRwReady = 1'b1;
    #1;
    checkOutput("mrRegrantRdy", 64'(aReady), 64'b10);
    tick();
    aRwReady = 1'b0;
    aValid = 2'b00;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
